// File: rtl/core_pkg.sv
// Shared core definitions for the instruction fetch stage.
//   XLEN          address / PC width
//   NOP_INSTR     addi x0,x0,0, shown when no valid instruction exists
//   fetch_entry_t IF/ID payload {pc, instr, fault}; also the T of the
//                 IF/ID pipeline register
//   FETCH_NOP     bubble value of fetch_entry_t
package core_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic            fault;
   } fetch_entry_t;

   localparam fetch_entry_t FETCH_NOP = '{pc: '0, instr: NOP_INSTR, fault: 1'b0};

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order queue of fetch entries.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   enq, enq_data  push one entry (dropped if full and not popping)
//   deq            pop the head (ignored when empty)
//   flush          empty the queue; wins over enq and deq
//   head           oldest entry (entry 0); undefined when count == 0
//   count          occupancy, 0..2
module fetch_buffer
   import core_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         enq,
   input  fetch_entry_t enq_data,
   input  logic         deq,
   input  logic         flush,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   logic [1:0]   count_q, count_d;
   fetch_entry_t entry0_q, entry0_d;
   fetch_entry_t entry1_q, entry1_d;
   logic         do_deq;
   logic         do_enq;

   // Entry 0 is always the head; a pop shifts entry 1 down.
   always_comb begin
      count_d  = count_q;
      entry0_d = entry0_q;
      entry1_d = entry1_q;
      do_deq   = deq && (count_q != 2'd0);
      do_enq   = enq && ((count_q != 2'd2) || do_deq);

      if (flush) begin
         count_d = 2'd0;
      end else begin
         case ({do_enq, do_deq})
            2'b10: begin
               if (count_q == 2'd0) entry0_d = enq_data;
               else                 entry1_d = enq_data;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               entry0_d = entry1_q;
               count_d  = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  entry0_d = enq_data;
               end else begin
                  entry0_d = entry1_q;
                  entry1_d = enq_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) count_q <= 2'd0;
      else          count_q <= count_d;
   end

   // Payload storage needs no reset: it is only read while count != 0.
   always_ff @(posedge clk) begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
   end

   assign head  = entry0_q;
   assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches on a
// valid/ready request channel, queues returned instructions and presents
// the head as the IF/ID payload.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   stall                     IF/ID holding; head not consumed
//   redirect_valid/_pc        control-flow redirect from execute
//   imem_req_valid/_ready/_addr  fetch request channel
//   imem_rsp_valid/_data/_err    in-order response, no backpressure
//   if_valid/_pc/_instr/_fault   head entry (NOP bubble when empty)
module fetch_unit #(
   parameter int               XLEN      = 32,
   parameter logic [XLEN-1:0]  RESET_PC  = '0,
   parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            imem_rsp_err,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_instr,
   output logic            if_fault
);

   import core_pkg::*;

   // pc_q: next address to request. addr_q: address of the single
   // in-flight request (pending = presented but not accepted,
   // outstanding = accepted, awaiting response; never both).
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic            pending_q, pending_d;
   logic            outstanding_q, outstanding_d;
   logic            stale_q, stale_d;
   logic            halted_q, halted_d;
   // A misaligned redirect owes one fault entry to the queue.
   logic            mis_q, mis_d;

   logic            rsp_live;
   logic            rsp_fault;
   logic            mis_enq;
   logic            issue_new;
   logic            accept;
   logic            consume;
   logic [2:0]      occ_next;

   logic            buf_enq;
   fetch_entry_t    buf_enq_data;
   fetch_entry_t    buf_head;
   logic [1:0]      buf_count;

   assign if_valid = (buf_count != 2'd0);
   assign consume  = if_valid && !stall;

   always_comb begin
      pc_d          = pc_q;
      addr_d        = addr_q;
      pending_d     = pending_q;
      outstanding_d = outstanding_q;
      stale_d       = stale_q;
      halted_d      = halted_q;
      mis_d         = mis_q;
      buf_enq       = 1'b0;
      buf_enq_data  = FETCH_NOP;

      rsp_live  = imem_rsp_valid && !stale_q;
      rsp_fault = rsp_live && imem_rsp_err;
      mis_enq   = mis_q && !stale_q;

      if (rsp_live) begin
         buf_enq            = 1'b1;
         buf_enq_data.pc    = addr_q;
         buf_enq_data.instr = imem_rsp_err ? NOP_INSTR : imem_rsp_data;
         buf_enq_data.fault = imem_rsp_err;
      end else if (mis_enq) begin
         buf_enq            = 1'b1;
         buf_enq_data.pc    = pc_q;
         buf_enq_data.instr = NOP_INSTR;
         buf_enq_data.fault = 1'b1;
      end

      // Occupancy at the end of this cycle; a new request must leave a
      // free slot for its own response.
      occ_next = {1'b0, buf_count} + {2'b00, buf_enq} - {2'b00, consume};

      // No request on a redirect cycle: pc_q still holds the old path.
      issue_new = reset_n && !pending_q && !halted_q && !redirect_valid &&
                  !rsp_fault && (!outstanding_q || imem_rsp_valid) &&
                  (occ_next <= 3'd1);

      imem_req_valid = pending_q || issue_new;
      imem_req_addr  = pending_q ? addr_q : pc_q;
      accept         = imem_req_valid && imem_req_ready;

      if (imem_rsp_valid) begin
         outstanding_d = 1'b0;
         stale_d       = 1'b0;
      end
      if (rsp_fault) halted_d = 1'b1;
      if (mis_enq)   mis_d    = 1'b0;

      if (issue_new) addr_d = pc_q;

      if (accept) begin
         outstanding_d = 1'b1;
         pending_d     = 1'b0;
         // A stale pending request was issued from the old path; pc_q
         // already points at the redirect target and must not advance.
         if (!(pending_q && stale_q)) pc_d = pc_q + XLEN'(4);
      end else if (issue_new) begin
         pending_d = 1'b1;
      end

      if (redirect_valid) begin
         pc_d     = redirect_pc;
         halted_d = |redirect_pc[1:0];
         mis_d    = |redirect_pc[1:0];
         if (pending_q || (outstanding_q && !imem_rsp_valid)) stale_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q          <= RESET_PC;
         pending_q     <= 1'b0;
         outstanding_q <= 1'b0;
         stale_q       <= 1'b0;
         halted_q      <= 1'b0;
         mis_q         <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         pending_q     <= pending_d;
         outstanding_q <= outstanding_d;
         stale_q       <= stale_d;
         halted_q      <= halted_d;
         mis_q         <= mis_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q <= addr_d;
   end

   fetch_buffer u_fetch_buffer (
      .clk      (clk),
      .reset_n  (reset_n),
      .enq      (buf_enq),
      .enq_data (buf_enq_data),
      .deq      (consume),
      .flush    (redirect_valid),
      .head     (buf_head),
      .count    (buf_count)
   );

   assign if_pc    = if_valid ? buf_head.pc    : '0;
   assign if_instr = if_valid ? buf_head.instr : NOP_INSTR;
   assign if_fault = if_valid ? buf_head.fault : 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_fault;
   logic        err_en;
   logic        done = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_fault       (if_fault)
   );

   // 1-cycle instruction memory: word at address A reads as A ^ 5A5A_0000;
   // with err_en, address 0x20 returns an access fault.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         imem_rsp_valid <= 1'b0;
         imem_rsp_data  <= '0;
         imem_rsp_err   <= 1'b0;
      end else begin
         imem_rsp_valid <= imem_req_valid && imem_req_ready;
         imem_rsp_data  <= imem_req_addr ^ 32'h5A5A_0000;
         imem_rsp_err   <= err_en && (imem_req_addr == 32'h0000_0020);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
      chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, {31'b0, v});
      if (v) chk({tag, "_req_addr"}, imem_req_addr, a);
   endtask

   task automatic chk_if(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] instr, input logic f);
      chk({tag, "_if_valid"}, {31'b0, if_valid}, {31'b0, v});
      chk({tag, "_if_pc"},    if_pc, pc);
      chk({tag, "_if_instr"}, if_instr, instr);
      chk({tag, "_if_fault"}, {31'b0, if_fault}, {31'b0, f});
   endtask

   task automatic chk_empty(input string tag);
      chk_if(tag, 1'b0, 32'h0, NOP, 1'b0);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #5000;
      if (!done) begin
         $display("FAIL watchdog: observed timeout expected completion");
         $fatal(1, "watchdog expired");
      end
   end

   initial begin
      reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; err_en = 1'b0;
      repeat (3) tick();
      #1;
      chk_req("rst", 1'b0, 32'h0);
      chk_empty("rst");

      // Streaming from reset, one instruction per cycle
      tick(); reset_n = 1'b1; #1;
      chk_req("t0", 1'b1, 32'h0);   chk_empty("t0");
      tick(); #1;
      chk_req("t1", 1'b1, 32'h4);   chk_empty("t1");
      tick(); #1;
      chk_req("t2", 1'b1, 32'h8);   chk_if("t2", 1'b1, 32'h0, 32'h5A5A_0000, 1'b0);
      tick(); #1;
      chk_req("t3", 1'b1, 32'hC);   chk_if("t3", 1'b1, 32'h4, 32'h5A5A_0004, 1'b0);

      // Stall for 4 cycles: queue fills, requests stop, head holds
      tick(); stall = 1'b1; #1;
      chk_req("t4", 1'b0, 32'h0);   chk_if("t4", 1'b1, 32'h8, 32'h5A5A_0008, 1'b0);
      for (int i = 5; i < 8; i++) begin
         tick(); #1;
         chk_req("stall", 1'b0, 32'h0);
         chk_if("stall", 1'b1, 32'h8, 32'h5A5A_0008, 1'b0);
      end
      tick(); stall = 1'b0; #1;
      chk_req("t8", 1'b1, 32'h10);  chk_if("t8", 1'b1, 32'h8, 32'h5A5A_0008, 1'b0);

      // Redirect to 0x100 while 0x10 is in flight
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
      chk_req("t9", 1'b0, 32'h0);   chk_if("t9", 1'b1, 32'hC, 32'h5A5A_000C, 1'b0);
      tick(); redirect_valid = 1'b0; #1;
      chk_req("t10", 1'b1, 32'h100); chk_empty("t10");
      tick(); #1;
      chk_req("t11", 1'b1, 32'h104); chk_empty("t11");
      tick(); #1;
      chk_if("t12", 1'b1, 32'h100, 32'h5A5A_0100, 1'b0);

      // Ready low: address held, redirect makes it stale
      tick(); imem_req_ready = 1'b0; #1;
      chk_req("t13", 1'b1, 32'h10C); chk_if("t13", 1'b1, 32'h104, 32'h5A5A_0104, 1'b0);
      tick(); #1;
      chk_req("t14", 1'b1, 32'h10C); chk_if("t14", 1'b1, 32'h108, 32'h5A5A_0108, 1'b0);
      tick(); #1;
      chk_req("t15", 1'b1, 32'h10C); chk_empty("t15");
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
      chk_req("t16", 1'b1, 32'h10C); chk_empty("t16");
      tick(); redirect_valid = 1'b0; imem_req_ready = 1'b1; #1;
      chk_req("t17", 1'b1, 32'h10C); chk_empty("t17");
      tick(); #1;
      chk_req("t18", 1'b1, 32'h200); chk_empty("t18");
      tick(); #1;
      chk_req("t19", 1'b1, 32'h204); chk_empty("t19");

      // Access fault at 0x20
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h18; err_en = 1'b1; #1;
      chk_req("t20", 1'b0, 32'h0);  chk_if("t20", 1'b1, 32'h200, 32'h5A5A_0200, 1'b0);
      tick(); redirect_valid = 1'b0; #1;
      chk_req("t21", 1'b1, 32'h18); chk_empty("t21");
      tick(); #1;
      chk_req("t22", 1'b1, 32'h1C); chk_empty("t22");
      tick(); #1;
      chk_req("t23", 1'b1, 32'h20); chk_if("t23", 1'b1, 32'h18, 32'h5A5A_0018, 1'b0);
      tick(); #1;
      chk_req("t24", 1'b0, 32'h0);  chk_if("t24", 1'b1, 32'h1C, 32'h5A5A_001C, 1'b0);
      tick(); stall = 1'b1; #1;
      chk_req("t25", 1'b0, 32'h0);  chk_if("t25", 1'b1, 32'h20, NOP, 1'b1);
      tick(); #1;
      chk_req("t26", 1'b0, 32'h0);  chk_if("t26", 1'b1, 32'h20, NOP, 1'b1);
      // Redirect during stall: redirect wins, fetch resumes at 0x40
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
      chk_req("t27", 1'b0, 32'h0);  chk_if("t27", 1'b1, 32'h20, NOP, 1'b1);
      tick(); redirect_valid = 1'b0; stall = 1'b0; #1;
      chk_req("t28", 1'b1, 32'h40); chk_empty("t28");
      tick(); #1;
      chk_req("t29", 1'b1, 32'h44); chk_empty("t29");

      // Misaligned redirect to 0x102: one fault entry, no request
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
      chk_req("t30", 1'b0, 32'h0);  chk_if("t30", 1'b1, 32'h40, 32'h5A5A_0040, 1'b0);
      tick(); redirect_valid = 1'b0; #1;
      chk_req("t31", 1'b0, 32'h0);  chk_empty("t31");
      tick(); stall = 1'b1; #1;
      chk_req("t32", 1'b0, 32'h0);  chk_if("t32", 1'b1, 32'h102, NOP, 1'b1);
      tick(); #1;
      chk_req("t33", 1'b0, 32'h0);  chk_if("t33", 1'b1, 32'h102, NOP, 1'b1);
      tick(); stall = 1'b0; #1;
      chk_req("t34", 1'b0, 32'h0);  chk_if("t34", 1'b1, 32'h102, NOP, 1'b1);

      // PC wraps modulo 2^32
      tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
      chk_req("t35", 1'b0, 32'h0);  chk_empty("t35");
      tick(); redirect_valid = 1'b0; #1;
      chk_req("t36", 1'b1, 32'hFFFF_FFFC);
      tick(); #1;
      chk_req("t37", 1'b1, 32'h0);

      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the in-order RISC-V core. Owns the PC and issues word fetches to instruction memory over a valid/ready request channel.
- Buffers returned instructions in a 2-entry queue and presents them as the IF/ID payload. That payload is the signals_in of the IF/ID pipeline register.
- Honours the pipeline stall and the redirect from execute. Discards stale responses after a redirect.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction presented when no valid entry (addi x0,x0,0).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  IF/ID register holding; head entry not consumed this cycle
- redirect_valid  in  1  control-flow redirect (branch/jump/trap)
- redirect_pc  in  XLEN  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  response valid (no backpressure, in order, ≥1 cycle after acceptance)
- imem_rsp_data  in  32  instruction word
- imem_rsp_err  in  1  access fault on this response
- if_valid  out  1  head entry valid
- if_pc  out  XLEN  head entry PC
- if_instr  out  32  head entry instruction
- if_fault  out  1  head entry carries fetch fault

Behaviour:
- Reset (async): pc=RESET_PC, queue empty, outstanding=0, stale=0, halted=0, imem_req_valid=0. Outputs: if_valid=0, if_pc=0, if_instr=NOP_INSTR, if_fault=0.
- Empty queue: outputs are the same values as in reset.
- Consume: the head dequeues on a cycle with if_valid && !stall.
- Request handshake:
  - imem_req_valid, once high, holds with a stable address until imem_req_ready. It is never withdrawn, including on redirect.
  - On acceptance: pc <= pc+4 (wraps modulo 2^XLEN), outstanding <= 1.
- Issue rule:
  - Assert a new request only if !halted and (outstanding==0, or a response arrives this cycle).
  - Also require queue occupancy after this cycle + 1 ≤ 2. This guarantees a response always has a slot.
  - With a 1-cycle memory and no stall, throughput is one instruction per cycle.
- Response, non-stale: enqueue {pc_of_request, data, err}; outstanding <= 0.
  - If err=1: the entry has fault=1, instr=NOP_INSTR, and halted <= 1. No further requests until redirect.
- Response, stale: dropped; stale <= 0, outstanding <= 0.
- Redirect (highest priority; overrides stall for the queue):
  - Queue cleared the same cycle; no enqueue of any response arriving that cycle. halted <= 0.
  - pc <= redirect_pc for the next request.
  - An accepted-but-unanswered request, or a pending unaccepted request, is marked stale and its response is dropped. A pending unaccepted request keeps its old address until accepted.
  - If redirect_pc[1:0]!=0: no memory request. Enqueue one entry {redirect_pc, NOP_INSTR, fault=1} once the queue is free of stale traffic, then halt.
- Simultaneous redirect and stall: redirect wins and the queue clears.
- Simultaneous response and consume on a full queue is legal; the occupancy rule prevents overflow.
- The instruction memory is reset by the same reset_n, so no response returns after reset.

Decomposition:
- core_pkg:
  - XLEN and NOP_INSTR constants.
  - fetch_entry_t struct {pc, instr, fault}. fetch_entry_t is also the T of the IF/ID register; its NOP value is {0, NOP_INSTR, 0}.
- Sub-module fetch_buffer: 2-entry FIFO of fetch_entry_t.
  - Ports: enq, deq, flush, head, count.
  - Flush has priority over enq/deq.
- The PC, request, stale and halt control stays in fetch_unit.

Test Plan:
- Reset release, 1-cycle memory, ready=1, no stall -> requests to 0x0,0x4,0x8 on consecutive cycles; if_valid from cycle 2 with one entry per cycle, pc 0x0,0x4,0x8.
- Stall held 4 cycles mid-stream -> queue fills to 2; imem_req_valid drops; if_pc is constant. After release, in-order delivery with no lost or duplicate PC.
- Redirect to 0x100 while a request to 0x10 is outstanding -> the 0x10 response is dropped; the next if_pc is 0x100, then 0x104.
- imem_req_ready low 3 cycles, then redirect -> address is held until accept, the response is discarded, then fetch resumes at the redirect target.
- Response with imem_rsp_err at 0x20 -> entry {0x20, 0x13, fault=1}; no further requests; redirect to 0x40 resumes fetch.
- Redirect to 0x102 -> single entry {0x102, 0x13, fault=1}; no imem request issued.
